rob_commit: RTL

- Reorder buffer and in-order commit stage of the out_of_order core.
- Allocates an entry per dispatched instruction and captures results broadcast on the CDB.
- Retires at most one instruction per cycle into the architectural register file (`registers`), which is what the top-level bench checks.
- On a mispredicted branch reaching the head, issues a pipeline flush and redirect PC.

---
 rtl/ooo_pkg.sv | 20 ++
 rtl/rob_ptr.sv | 17 +
 rtl/rob_commit.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order core: ROB entry layout, tag type and core-wide widths.
package ooo_pkg;
    localparam int XLEN      = 32;
    localparam int ROB_DEPTH = 16;
    localparam int ARCH_REGS = 32;
    localparam int ROB_TAG_W = $clog2(ROB_DEPTH);
    localparam int RD_W      = $clog2(ARCH_REGS);

    typedef logic [ROB_TAG_W-1:0] rob_tag_t;

    typedef struct packed {
        logic            valid;
        logic            done;
        logic [RD_W-1:0] rd;
        logic            is_store;
        logic            mispredict;
        logic [XLEN-1:0] value;
        logic [XLEN-1:0] target;
    } rob_entry_t;
endpackage

// File: rtl/rob_ptr.sv
// Wrap-around ROB pointer; DEPTH is a power of two so natural overflow wraps it.
module rob_ptr #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] ptr
);
    always_ff @(posedge clk) begin
        if (reset || clr)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end
endmodule

// File: rtl/rob_commit.sv
// Reorder buffer with in-order single-wide commit and mispredict flush.
// Optional ROB_STATS_EN adds saturating commit/flush/full-cycle counters.
module rob_commit #(
    parameter int DEPTH = 16,
    parameter int TAG_W = $clog2(DEPTH),
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             alloc_valid,
    output logic             alloc_ready,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_store,
    input  logic [XLEN-1:0]  alloc_pc,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [XLEN-1:0]  cdb_value,
    input  logic             cdb_mispredict,
    input  logic [XLEN-1:0]  cdb_target,
    input  logic [TAG_W-1:0] q_tag,
    output logic             q_ready,
    output logic [XLEN-1:0]  q_value,
    output logic             rf_we,
    output logic [4:0]       rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
    output logic             store_commit,
    output logic [TAG_W-1:0] store_commit_tag,
    output logic             flush,
    output logic [XLEN-1:0]  flush_pc,
    output logic             empty
`ifdef ROB_STATS_EN
    ,
    output logic [31:0]      stat_commits,
    output logic [31:0]      stat_flushes,
    output logic [31:0]      stat_full_cycles
`endif
);
    import ooo_pkg::*;

    rob_entry_t       rob [DEPTH];
    logic [TAG_W-1:0] head, tail;
    logic [TAG_W:0]   count;
    rob_entry_t       head_e;
    logic             commit, alloc_fire, full;

    assign head_e     = rob[head];
    // Commit is suppressed during reset so no stale head can retire in that cycle.
    assign commit     = !reset && head_e.valid && head_e.done;
    assign flush      = commit && head_e.mispredict;
    assign full       = (count == (TAG_W+1)'(DEPTH));
    assign alloc_ready = !full && !flush;
    assign alloc_fire = alloc_valid && alloc_ready;
    assign alloc_tag  = tail;
    assign empty      = (count == '0);

    assign rf_we            = commit && (head_e.rd != '0) && !head_e.is_store;
    assign rf_waddr         = head_e.rd;
    assign rf_wdata         = head_e.value;
    assign store_commit     = commit && head_e.is_store;
    assign store_commit_tag = head;
    assign flush_pc         = flush ? head_e.target : '0;

    assign q_ready = rob[q_tag].valid && rob[q_tag].done;
    assign q_value = rob[q_tag].value;

    rob_ptr #(.W(TAG_W)) u_head (
        .clk(clk), .reset(reset), .inc(commit), .clr(flush), .ptr(head)
    );
    rob_ptr #(.W(TAG_W)) u_tail (
        .clk(clk), .reset(reset), .inc(alloc_fire), .clr(flush), .ptr(tail)
    );

    always_ff @(posedge clk) begin
        if (reset || flush)
            count <= '0;
        else if (alloc_fire && !commit)
            count <= count + 1'b1;
        else if (!alloc_fire && commit)
            count <= count - 1'b1;
    end

    // Later statements win: commit frees the head, allocation overrides a same-tag CDB write.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (reset || flush) begin
                rob[i].valid <= 1'b0;
                rob[i].done  <= 1'b0;
            end else begin
                if (cdb_valid && cdb_tag == TAG_W'(i) && rob[i].valid) begin
                    rob[i].done       <= 1'b1;
                    rob[i].value      <= cdb_value;
                    rob[i].mispredict <= cdb_mispredict;
                    rob[i].target     <= cdb_target;
                end
                if (commit && head == TAG_W'(i)) begin
                    rob[i].valid <= 1'b0;
                    rob[i].done  <= 1'b0;
                end
                if (alloc_fire && tail == TAG_W'(i)) begin
                    rob[i].valid      <= 1'b1;
                    rob[i].done       <= 1'b0;
                    rob[i].rd         <= alloc_rd;
                    rob[i].is_store   <= alloc_is_store;
                    rob[i].mispredict <= 1'b0;
                end
            end
        end
    end

    logic unused_pc;
    assign unused_pc = ^alloc_pc;

`ifdef ROB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_commits     <= '0;
            stat_flushes     <= '0;
            stat_full_cycles <= '0;
        end else begin
            if (commit && stat_commits != '1)     stat_commits     <= stat_commits + 1'b1;
            if (flush && stat_flushes != '1)      stat_flushes     <= stat_flushes + 1'b1;
            if (full && stat_full_cycles != '1)   stat_full_cycles <= stat_full_cycles + 1'b1;
        end
    end
`endif
endmodule
